// File: rtl/jtag_strap_pkg.sv
// Shared types for the JTAG/boot strap controller: FSM encoding, strap bit indices
// and a small state classification helper.
package jtag_strap_pkg;

  typedef enum logic [4:0] {
    StIdle     = 5'b00011,
    StSettle   = 5'b00101,
    StSample   = 5'b01001,
    StHandover = 5'b10001,
    StLocked   = 5'b11110
  } strap_state_e;

  localparam int unsigned StrapJtagIdx = 0;
  localparam int unsigned StrapBootIdx = 1;

  function automatic logic state_is_busy(input strap_state_e s);
    return (s == StSettle) || (s == StSample) || (s == StHandover);
  endfunction

endpackage

// File: rtl/jtag_strap_ctrl_if.sv
// Strap controller bus: padring/pwrmgr/lc inputs and the overlay-mux facing outputs.
interface jtag_strap_ctrl_if #(
  parameter int unsigned NumStraps = 2
);
  logic [NumStraps-1:0] strap_i;
  logic                 sample_req_i;
  logic                 lc_hw_debug_en_i;
  logic [NumStraps-1:0] strap_o;
  logic                 strap_valid_o;
  logic                 timeout_o;
  logic                 quiesce_o;
  logic                 jtag_en_o;
  logic                 busy_o;

  modport slave (
    input  strap_i, sample_req_i, lc_hw_debug_en_i,
    output strap_o, strap_valid_o, timeout_o, quiesce_o, jtag_en_o, busy_o
  );

  modport master (
    output strap_i, sample_req_i, lc_hw_debug_en_i,
    input  strap_o, strap_valid_o, timeout_o, quiesce_o, jtag_en_o, busy_o
  );
endinterface

// File: rtl/jtag_strap_debounce.sv
// Candidate register plus run-length counter; o_done flags the sample that completes
// DebounceCycles consecutive identical values of the whole strap vector.
module jtag_strap_debounce
  import jtag_strap_pkg::*;
#(
  parameter int unsigned Width          = 2,
  parameter int unsigned DebounceCycles = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_cand,
  output logic             o_done
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0] r_cand;
  logic [CntW-1:0]  r_cnt;
  logic             w_match;

  assign w_match = (i_data == r_cand);

  // Candidate tracking; any mismatch restarts the run with the new value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cand <= {Width{1'b0}};
      r_cnt  <= {CntW{1'b0}};
    end else if (i_load) begin
      r_cand <= i_data;
      r_cnt  <= {CntW{1'b0}};
    end else if (i_en) begin
      if (!w_match) begin
        r_cand <= i_data;
        r_cnt  <= {CntW{1'b0}};
      end else if (r_cnt != CntMax) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_cand <= r_cand;
      r_cnt  <= r_cnt;
    end
  end

  assign o_cand = r_cand;
  assign o_done = i_en & w_match & (r_cnt == CntLast);

endmodule

// File: rtl/jtag_strap_param_chk.sv
// Elaboration-time legality check of the strap controller parameter set.
module jtag_strap_param_chk #(
  parameter int unsigned SettleCycles   = 4,
  parameter int unsigned DebounceCycles = 8,
  parameter int unsigned TimeoutCycles  = 256,
  parameter int unsigned QuiesceCycles  = 2
) ();

  if ((DebounceCycles < 1) || (TimeoutCycles <= DebounceCycles + 1) ||
      (QuiesceCycles < 1) || (SettleCycles < 1)) begin : g_bad_params
    $error("jtag_strap_ctrl: illegal parameter set");
  end

endmodule

// File: rtl/jtag_strap_ctrl.sv
// Strap sampling, debounce, lifecycle qualification and JTAG/SPI pad handover sequencing.
// Optional: define JTAG_STRAP_RESAMPLE_EN to allow re-sampling from Locked on sample_req_i.
module jtag_strap_ctrl
  import jtag_strap_pkg::*;
#(
  parameter int unsigned SettleCycles   = 4,
  parameter int unsigned DebounceCycles = 8,
  parameter int unsigned TimeoutCycles  = 256,
  parameter int unsigned QuiesceCycles  = 2,
  parameter int unsigned NumStraps      = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  jtag_strap_ctrl_if.slave  bus
);

  localparam int unsigned SetW  = $clog2(SettleCycles + 1);
  localparam int unsigned ToW   = $clog2(TimeoutCycles + 1);
  localparam int unsigned HandW = $clog2(QuiesceCycles + 1);

  logic [NumStraps-1:0] r_sync1, r_sync2;
  strap_state_e         r_state, w_state_nxt;
  logic [SetW-1:0]      r_settle_cnt;
  logic [ToW-1:0]       r_to_cnt;
  logic [HandW-1:0]     r_hand_cnt;
  logic [NumStraps-1:0] r_strap, w_strap_nxt, w_deb_cand;
  logic r_valid, r_timeout, r_quiesce, r_jtag_en, r_busy;
  logic w_valid_nxt, w_timeout_nxt, w_quiesce_nxt, w_jtag_en_nxt, w_busy_nxt;
  logic w_deb_done, w_settle_done, w_timeout_hit, w_hand_done, w_lc_en;

  jtag_strap_param_chk #(
    .SettleCycles(SettleCycles), .DebounceCycles(DebounceCycles),
    .TimeoutCycles(TimeoutCycles), .QuiesceCycles(QuiesceCycles)
  ) u_param_chk ();

`ifdef JTAG_STRAP_RESAMPLE_EN
  logic w_req;
  assign w_req = bus.sample_req_i;
`else
  logic w_unused_sample_req;
  assign w_unused_sample_req = bus.sample_req_i;
`endif

  assign w_lc_en = bus.lc_hw_debug_en_i;

  // Two-flop synchronizer for the asynchronous strap pads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= {NumStraps{1'b0}};
      r_sync2 <= {NumStraps{1'b0}};
    end else begin
      r_sync1 <= bus.strap_i;
      r_sync2 <= r_sync1;
    end
  end

  jtag_strap_debounce #(
    .Width(NumStraps), .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (r_state != StSample),
    .i_en   (r_state == StSample),
    .i_data (r_sync2),
    .o_cand (w_deb_cand),
    .o_done (w_deb_done)
  );

  // Per-state saturating counters, held at zero outside their own state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_settle_cnt <= {SetW{1'b0}};
      r_to_cnt     <= {ToW{1'b0}};
      r_hand_cnt   <= {HandW{1'b0}};
    end else begin
      if (r_state != StSettle)                          r_settle_cnt <= {SetW{1'b0}};
      else if (r_settle_cnt != SetW'(SettleCycles))     r_settle_cnt <= r_settle_cnt + SetW'(1);
      else                                              r_settle_cnt <= r_settle_cnt;
      if (r_state != StSample)                          r_to_cnt <= {ToW{1'b0}};
      else if (r_to_cnt != ToW'(TimeoutCycles))         r_to_cnt <= r_to_cnt + ToW'(1);
      else                                              r_to_cnt <= r_to_cnt;
      if (r_state != StHandover)                        r_hand_cnt <= {HandW{1'b0}};
      else if (r_hand_cnt != HandW'(QuiesceCycles))     r_hand_cnt <= r_hand_cnt + HandW'(1);
      else                                              r_hand_cnt <= r_hand_cnt;
    end
  end

  assign w_settle_done = (r_state == StSettle)   && (r_settle_cnt == SetW'(SettleCycles - 1));
  assign w_timeout_hit = (r_state == StSample)   && (r_to_cnt == ToW'(TimeoutCycles - 1));
  assign w_hand_done   = (r_state == StHandover) && (r_hand_cnt == HandW'(QuiesceCycles));

  // State register; reset lands in Settle so straps are sampled without a request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StSettle;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef JTAG_STRAP_RESAMPLE_EN
      StIdle:     w_state_nxt = w_req ? StSettle : StIdle;
`endif
      StSettle:   w_state_nxt = w_settle_done ? StSample : StSettle;
      StSample:   w_state_nxt = (w_deb_done || w_timeout_hit) ? StHandover : StSample;
      StHandover: w_state_nxt = w_hand_done ? StLocked : StHandover;
`ifdef JTAG_STRAP_RESAMPLE_EN
      StLocked:   w_state_nxt = w_req ? StSettle : StLocked;
`else
      StLocked:   w_state_nxt = StLocked;
`endif
      default:    w_state_nxt = StLocked;
    endcase
  end

  // Next values of the registered outputs; losing debug enable always drops jtag_en.
  always_comb begin
    w_strap_nxt   = r_strap;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = r_timeout;
    w_quiesce_nxt = 1'b0;
    w_jtag_en_nxt = r_jtag_en & w_lc_en;
    case (r_state)
`ifdef JTAG_STRAP_RESAMPLE_EN
      StIdle: begin
        if (w_req) begin
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
        end else begin
          w_valid_nxt   = r_valid;
        end
      end
`endif
      StSettle: begin
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
      end
      StSample: begin
        if (w_deb_done) begin
          w_strap_nxt   = w_deb_cand;
          w_quiesce_nxt = 1'b1;
        end else if (w_timeout_hit) begin
          w_strap_nxt   = {NumStraps{1'b0}};
          w_timeout_nxt = 1'b1;
          w_quiesce_nxt = 1'b1;
        end else begin
          w_quiesce_nxt = 1'b0;
        end
      end
      StHandover: begin
        if (w_hand_done) begin
          w_quiesce_nxt = 1'b0;
          w_valid_nxt   = 1'b1;
        end else begin
          w_quiesce_nxt = 1'b1;
        end
        if (r_hand_cnt == {HandW{1'b0}}) w_jtag_en_nxt = r_strap[StrapJtagIdx] & w_lc_en;
        else                             w_jtag_en_nxt = r_jtag_en & w_lc_en;
      end
      StLocked: begin
`ifdef JTAG_STRAP_RESAMPLE_EN
        if (w_req) begin
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
        end else begin
          w_valid_nxt   = r_valid;
        end
`else
        w_strap_nxt = r_strap;
`endif
      end
      default: begin
        w_jtag_en_nxt = 1'b0;
        w_quiesce_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = state_is_busy(w_state_nxt);
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_strap   <= {NumStraps{1'b0}};
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_quiesce <= 1'b0;
      r_jtag_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_strap   <= w_strap_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_quiesce <= w_quiesce_nxt;
      r_jtag_en <= w_jtag_en_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.strap_o       = r_strap;
  assign bus.strap_valid_o = r_valid;
  assign bus.timeout_o     = r_timeout;
  assign bus.quiesce_o     = r_quiesce;
  assign bus.jtag_en_o     = r_jtag_en;
  assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_jtag_strap_ctrl.sv
// Directed bench for jtag_strap_ctrl; edge numbers count posedges after reset release.
module tb_jtag_strap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  int   edge_n = 0;

  jtag_strap_ctrl_if #(.NumStraps(2)) bus ();

  jtag_strap_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic v, input logic to,
                         input logic q, input logic j, input logic b);
    chk({tag, ".strap"},   {30'd0, bus.strap_o},   {30'd0, s});
    chk({tag, ".valid"},   {31'd0, bus.strap_valid_o}, {31'd0, v});
    chk({tag, ".timeout"}, {31'd0, bus.timeout_o}, {31'd0, to});
    chk({tag, ".quiesce"}, {31'd0, bus.quiesce_o}, {31'd0, q});
    chk({tag, ".jtag_en"}, {31'd0, bus.jtag_en_o}, {31'd0, j});
    chk({tag, ".busy"},    {31'd0, bus.busy_o},    {31'd0, b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut(input logic [1:0] s, input logic lc);
    rst_n = 1'b0;
    bus.strap_i = s;
    bus.lc_hw_debug_en_i = lc;
    bus.sample_req_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  function automatic logic [1:0] pat(input int e);
    return (((e / 5) % 2) == 1) ? 2'b11 : 2'b00;
  endfunction

  initial begin
    // Clean sample of 01 with debug enabled; req pulse in Sample is ignored.
    bus.strap_i = 2'b01;
    bus.lc_hw_debug_en_i = 1'b1;
    bus.sample_req_i = 1'b0;
    tick();
    tick();
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    edge_n = 0;
    ticks(4);
    chk_all("clean.settle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2);
    bus.sample_req_i = 1'b1;
    tick();
    bus.sample_req_i = 1'b0;
    ticks(4);
    chk_all("clean.sample_end", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("clean.h0", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("clean.h1", 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("clean.h2", 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("clean.locked", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.lc_hw_debug_en_i = 1'b0;
    tick();
    chk_all("lc_drop", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.lc_hw_debug_en_i = 1'b1;
    ticks(3);
    chk_all("lc_reassert", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch to 00 seen at debounce count 6: acceptance moves from edge 15 to 23.
    reset_dut(2'b01, 1'b1);
    for (int e = 1; e <= 22; e++) begin
      tick();
      bus.strap_i = (edge_n == 8) ? 2'b00 : 2'b01;
    end
    chk_all("glitch.pre", 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("glitch.locked", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Debug disabled: strap accepted but JTAG overlay stays off.
    reset_dut(2'b01, 1'b0);
    ticks(15);
    chk_all("nodebug", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Strap toggling every 5 cycles never settles: timeout after 256 Sample cycles.
    reset_dut(pat(0), 1'b1);
    for (int e = 1; e <= 259; e++) begin
      tick();
      bus.strap_i = pat(edge_n);
    end
    chk_all("timeout.pre", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("timeout.hit", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(3);
    chk_all("timeout.locked", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Debounce completes on the very timeout cycle: debounce wins.
    reset_dut(pat(0), 1'b1);
    for (int e = 1; e <= 259; e++) begin
      tick();
      bus.strap_i = (edge_n >= 249) ? 2'b10 : pat(edge_n);
    end
    chk_all("tie.pre", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("tie.hit", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);
    chk_all("tie.locked", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of Handover, then a full resample.
    reset_dut(2'b01, 1'b1);
    ticks(13);
    chk_all("rst.h1", 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_dut(2'b01, 1'b1);
    ticks(15);
    chk_all("rst.resampled", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Request while Locked with straps changed to 10.
    reset_dut(2'b01, 1'b1);
    ticks(15);
    chk_all("req.locked", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.strap_i = 2'b10;
    ticks(3);
    bus.sample_req_i = 1'b1;
    tick();
    bus.sample_req_i = 1'b0;
`ifdef JTAG_STRAP_RESAMPLE_EN
    chk_all("resample.settle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ticks(12);
    chk_all("resample.h0", 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("resample.h1", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(2);
    chk_all("resample.locked", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    chk_all("noresample.now", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(15);
    chk_all("noresample.later", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
